// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one completed unit result
// per cycle, broadcasts it on a registered CDB and acks the winning unit.
module cdb_arbiter #(
    parameter int unsigned N_UNITS   = 5,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_UNITS-1:0]             req,
    input  logic [N_UNITS*TAG_SIZE-1:0]    tag_in,
    input  logic [N_UNITS*WORD_SIZE-1:0]   data_in,
    input  logic                           flush,
    output logic [N_UNITS-1:0]             ack,
    output logic                           cdb_valid,
    output logic [TAG_SIZE-1:0]            cdb_tag,
    output logic [WORD_SIZE-1:0]           cdb_data,
    output logic [2:0]                     cdb_unit,
    output logic                           tag_err
);

    localparam int unsigned UNIT_W = 3;
    localparam logic [TAG_SIZE-1:0] RSVD_TAG = TAG_SIZE'(8'h7F);

    logic [TAG_SIZE-1:0]  tag_arr  [N_UNITS];
    logic [WORD_SIZE-1:0] data_arr [N_UNITS];

    logic [N_UNITS-1:0]   ack_q,   ack_d;
    logic                 valid_q, valid_d;
    logic [TAG_SIZE-1:0]  tag_q,   tag_d;
    logic [WORD_SIZE-1:0] data_q,  data_d;
    logic [UNIT_W-1:0]    unit_q,  unit_d;
    logic                 err_q,   err_d;
    logic [UNIT_W-1:0]    ptr_q,   ptr_d;

    logic [N_UNITS-1:0]   elig;
    logic                 found;
    logic [UNIT_W-1:0]    win;
    logic [UNIT_W-1:0]    idx;

    // Unpack the flat per-unit buses.
    for (genvar i = 0; i < N_UNITS; i++) begin : g_unpack
        assign tag_arr[i]  = tag_in[i*TAG_SIZE +: TAG_SIZE];
        assign data_arr[i] = data_in[i*WORD_SIZE +: WORD_SIZE];
    end

    // A unit acked last cycle still shows its old req, so mask it out this cycle.
    always_comb begin
        elig  = req & ~ack_q;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            idx = UNIT_W'((32'(ptr_q) + k) % N_UNITS);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        ack_d   = '0;
        valid_d = 1'b0;
        tag_d   = RSVD_TAG;
        data_d  = data_q;
        unit_d  = unit_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        if (flush) begin
            ptr_d = '0;
        end else if (found) begin
            ack_d = N_UNITS'(1) << win;
            ptr_d = (32'(win) == N_UNITS - 1) ? '0 : win + UNIT_W'(1);
            // Reserved-tag winner is consumed but never broadcast.
            if (tag_arr[win] == RSVD_TAG) begin
                err_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                tag_d   = tag_arr[win];
                data_d  = data_arr[win];
                unit_d  = win;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= RSVD_TAG;
            data_q  <= '0;
            unit_q  <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            unit_q  <= unit_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ack       = ack_q;
    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign cdb_unit  = unit_q;
    assign tag_err   = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table fed through an expectation
// queue, plus a hand-written asynchronous-reset sequence.
module tb_cdb_arbiter;

    localparam int unsigned N = 5;
    localparam int unsigned W = 32;
    localparam int unsigned T = 8;
    localparam int unsigned NV = 22;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*T-1:0]   tag_in;
    logic [N*W-1:0]   data_in;
    logic             flush;
    logic [N-1:0]     ack;
    logic             cdb_valid;
    logic [T-1:0]     cdb_tag;
    logic [W-1:0]     cdb_data;
    logic [2:0]       cdb_unit;
    logic             tag_err;

    cdb_arbiter #(.N_UNITS(N), .WORD_SIZE(W), .TAG_SIZE(T)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tag_in(tag_in), .data_in(data_in),
        .flush(flush), .ack(ack), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_unit(cdb_unit), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         flush;
        logic [2:0]   cu;      // unit whose tag/data change before this step (7 = none)
        logic [T-1:0] ct;
        logic [W-1:0] cd;
        logic [N-1:0] e_ack;
        logic         e_valid;
        logic [T-1:0] e_tag;
        logic [W-1:0] e_data;
        logic [2:0]   e_unit;
        logic         e_err;
    } vec_t;

    typedef struct {
        logic [N-1:0] ack;
        logic         valid;
        logic [T-1:0] tag;
        logic [W-1:0] data;
        logic [2:0]   unit;
        logic         err;
    } exp_t;

    vec_t         vt [NV];
    exp_t         sb [$];
    logic [T-1:0] cur_tag  [N];
    logic [W-1:0] cur_data [N];
    int           total = 0;
    int           bad = 0;

    function automatic vec_t mk(logic [N-1:0] r, logic f, logic [2:0] cu, logic [T-1:0] ct,
                                logic [W-1:0] cd, logic [N-1:0] ea, logic ev, logic [T-1:0] et,
                                logic [W-1:0] ed, logic [2:0] eu, logic ee);
        vec_t v;
        v.req = r; v.flush = f; v.cu = cu; v.ct = ct; v.cd = cd;
        v.e_ack = ea; v.e_valid = ev; v.e_tag = et; v.e_data = ed; v.e_unit = eu; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_all(input string pfx, input exp_t e);
        chk({pfx, ".ack"},   W'(ack),       W'(e.ack));
        chk({pfx, ".valid"}, W'(cdb_valid), W'(e.valid));
        chk({pfx, ".tag"},   W'(cdb_tag),   W'(e.tag));
        chk({pfx, ".data"},  cdb_data,      e.data);
        chk({pfx, ".unit"},  W'(cdb_unit),  W'(e.unit));
        chk({pfx, ".err"},   W'(tag_err),   W'(e.err));
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            tag_in[i*T +: T]  = cur_tag[i];
            data_in[i*W +: W] = cur_data[i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;
        exp_t rst_e;
        // Table: inputs applied before an edge, outputs expected right after it.
        vt[0]  = mk(5'b00000, 0, 7, 0, 0,               5'b00000, 0, 8'h7F, 32'h0,        0, 0);
        vt[1]  = mk(5'b00000, 0, 7, 0, 0,               5'b00000, 0, 8'h7F, 32'h0,        0, 0);
        vt[2]  = mk(5'b00100, 0, 2, 8'h03, 32'hFFFFFFF9, 5'b00100, 1, 8'h03, 32'hFFFFFFF9, 2, 0);
        vt[3]  = mk(5'b00100, 0, 2, 8'h04, 32'h00000055, 5'b00000, 0, 8'h7F, 32'hFFFFFFF9, 2, 0);
        vt[4]  = mk(5'b00100, 0, 7, 0, 0,               5'b00100, 1, 8'h04, 32'h00000055, 2, 0);
        vt[5]  = mk(5'b00000, 0, 7, 0, 0,               5'b00000, 0, 8'h7F, 32'h00000055, 2, 0);
        vt[6]  = mk(5'b11111, 1, 7, 0, 0,               5'b00000, 0, 8'h7F, 32'h00000055, 2, 0);
        vt[7]  = mk(5'b11111, 0, 2, 8'h22, 32'hA0000002, 5'b00001, 1, 8'h20, 32'hA0000000, 0, 0);
        vt[8]  = mk(5'b11110, 0, 7, 0, 0,               5'b00010, 1, 8'h21, 32'hA0000001, 1, 0);
        vt[9]  = mk(5'b11100, 0, 7, 0, 0,               5'b00100, 1, 8'h22, 32'hA0000002, 2, 0);
        vt[10] = mk(5'b11000, 0, 7, 0, 0,               5'b01000, 1, 8'h23, 32'hA0000003, 3, 0);
        vt[11] = mk(5'b10000, 0, 7, 0, 0,               5'b10000, 1, 8'h24, 32'hA0000004, 4, 0);
        vt[12] = mk(5'b00000, 0, 7, 0, 0,               5'b00000, 0, 8'h7F, 32'hA0000004, 4, 0);
        vt[13] = mk(5'b01001, 0, 7, 0, 0,               5'b00001, 1, 8'h20, 32'hA0000000, 0, 0);
        vt[14] = mk(5'b01001, 0, 7, 0, 0,               5'b01000, 1, 8'h23, 32'hA0000003, 3, 0);
        vt[15] = mk(5'b01001, 0, 7, 0, 0,               5'b00001, 1, 8'h20, 32'hA0000000, 0, 0);
        vt[16] = mk(5'b01001, 0, 7, 0, 0,               5'b01000, 1, 8'h23, 32'hA0000003, 3, 0);
        vt[17] = mk(5'b00000, 0, 7, 0, 0,               5'b00000, 0, 8'h7F, 32'hA0000003, 3, 0);
        vt[18] = mk(5'b00010, 0, 1, 8'h7F, 32'hA0000001, 5'b00010, 0, 8'h7F, 32'hA0000003, 3, 1);
        vt[19] = mk(5'b10000, 1, 7, 0, 0,               5'b00000, 0, 8'h7F, 32'hA0000003, 3, 1);
        vt[20] = mk(5'b00110, 0, 1, 8'h21, 32'hA0000001, 5'b00010, 1, 8'h21, 32'hA0000001, 1, 1);
        vt[21] = mk(5'b00100, 0, 7, 0, 0,               5'b00100, 1, 8'h22, 32'hA0000002, 2, 1);

        rst_e.ack = '0; rst_e.valid = 1'b0; rst_e.tag = 8'h7F;
        rst_e.data = '0; rst_e.unit = '0; rst_e.err = 1'b0;

        for (int i = 0; i < N; i++) begin
            cur_tag[i]  = T'(8'h20 + i);
            cur_data[i] = W'(32'hA0000000 + i);
        end
        req = '0; flush = 1'b0; pack_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all("reset", rst_e);
        @(negedge clk) rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            if (vt[v].cu != 3'd7) begin
                cur_tag[vt[v].cu]  = vt[v].ct;
                cur_data[vt[v].cu] = vt[v].cd;
            end
            pack_inputs();
            req   = vt[v].req;
            flush = vt[v].flush;
            e.ack = vt[v].e_ack; e.valid = vt[v].e_valid; e.tag = vt[v].e_tag;
            e.data = vt[v].e_data; e.unit = vt[v].e_unit; e.err = vt[v].e_err;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: empty queue at vector %0d", v);
            end else begin
                e = sb.pop_front();
                chk_all($sformatf("vec%0d", v), e);
            end
        end

        // Asynchronous reset in the middle of a live broadcast with tag_err set.
        @(negedge clk);
        req = 5'b01000; flush = 1'b0;
        @(posedge clk);
        #1 chk("pre_rst.valid", W'(cdb_valid), W'(1'b1));
        chk("pre_rst.ack", W'(ack), W'(5'b01000));
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", rst_e);
        req = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk_all("post_rst_idle", rst_e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB) shared by the functional units behind the reservation stations: lw, sw, add, mul and mv.
- Each cycle it selects at most one unit's completed result (tag plus value) and broadcasts it on a registered CDB.
- The reservation stations and register file snoop the CDB for wakeup and writeback.
- It also acknowledges the winning unit so that unit can release its result.

Parameters:
- N_UNITS, 5, number of requesters; index = unit code: 0 lw, 1 sw, 2 add, 3 mul, 4 mv.
- WORD_SIZE, 32, result value width.
- TAG_SIZE, 8, producer tag width. Tag 8'h7F is reserved and means "value ready / no producer".

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  N_UNITS  bit i high = unit i holds a result for broadcast.
- tag_in  input  N_UNITS*TAG_SIZE  unit i tag in bits [i*TAG_SIZE +: TAG_SIZE].
- data_in  input  N_UNITS*WORD_SIZE  unit i value in bits [i*WORD_SIZE +: WORD_SIZE]; signed.
- flush  input  1  synchronous squash of all pending and in-flight broadcasts.
- ack  output  N_UNITS  one-hot, single-cycle pulse: unit i's result was taken.
- cdb_valid  output  1  CDB carries a valid broadcast this cycle.
- cdb_tag  output  TAG_SIZE  broadcast tag.
- cdb_data  output  WORD_SIZE  broadcast value.
- cdb_unit  output  3  unit index of the current broadcast.
- tag_err  output  1  sticky; set when a reserved-tag request was taken.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ack = 0, cdb_valid = 0, cdb_tag = 8'h7F, cdb_data = 0, cdb_unit = 0, tag_err = 0.
  - Round-robin pointer ptr = 0.
  - Reset asserted mid-broadcast drops that broadcast immediately.
- Eligibility at each edge: unit i is eligible when req[i] = 1 and ack[i] = 0.
  - ack[i] = 0 means the unit was not acked in the cycle ending at this edge.
  - This masking prevents a double grant, because a requester sees its ack one cycle late.
  - Consequence: one unit can win at most every other cycle.
- Selection: the first eligible unit in the order ptr, ptr+1, … wrapping modulo N_UNITS.
- Grant, registered with 1-cycle latency. At edge t with winner w:
  - cdb_valid <= 1, cdb_tag <= tag_in[w], cdb_data <= data_in[w], cdb_unit <= w.
  - ack <= one-hot(w).
  - ptr <= (w+1) mod N_UNITS; wraps from N_UNITS-1 to 0.
  - Broadcast and ack are both visible during cycle t+1.
- Requester rule: req, tag_in and data_in stay stable until ack is seen. On ack the unit may drop req or present its next result in the same cycle.
- No eligible unit: cdb_valid <= 0, ack <= 0, cdb_tag <= 8'h7F, cdb_data/cdb_unit hold, ptr holds.
- Reserved tag: a winner with tag_in = 8'h7F is acked and consumes its round-robin slot, but:
  - it is not broadcast: cdb_valid <= 0, cdb_tag <= 8'h7F;
  - tag_err <= 1, and it stays set until reset.
- flush = 1 at an edge, taking priority over everything:
  - ack <= 0, cdb_valid <= 0, cdb_tag <= 8'h7F, ptr <= 0.
  - Requests presented that cycle are ignored, not acked; units must re-present after the flush.
- Simultaneous requests: exactly one ack bit per cycle. Losers keep req high and are not acked.
- cdb_data is passed unmodified; there is no width conversion or sign change.
- Throughput: one broadcast per cycle whenever at least two units are eligible in alternation.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then req = 0 -> cdb_valid = 0, cdb_tag = 8'h7F, ack = 0 on every cycle.
- Single request: req = 5'b00100, tag_in[2] = 8'h03, data_in[2] = -7 -> next cycle cdb_valid = 1, cdb_tag = 8'h03, cdb_data = 32'hFFFFFFF9, cdb_unit = 2, ack = 5'b00100, ptr = 3.
- Held request: same unit keeps req high after its ack -> no grant in the ack cycle; re-granted one cycle later only with new data.
- Contention: req = 5'b11111 held from ptr = 0, units dropping req on ack -> ack order 0, 1, 2, 3, 4, one per cycle, and ptr wraps to 0.
- Fairness: req = 5'b01001 held continuously -> grants alternate between units 3 and 0; neither unit waits more than 1 cycle.
- Reserved tag, flush, and async reset:
  - unit 1 with tag 8'h7F -> ack = 5'b00010, cdb_valid = 0, tag_err = 1;
  - then flush with req = 5'b10000 -> no ack, ptr = 0;
  - rst_n dropped mid-cycle -> all outputs immediately return to reset values.
